// File: rtl/dmem_pkg.sv
// Shared encodings for the dmem_responder data-memory slave.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    // Wide enough for WAIT_CYCLES up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the right-justified bus value.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    // SIZE=11 falls into the word branch; unused low address bits are ignored
    always_comb begin
        byte_en = 4'b1111;
        wword   = wdata;
        rdata   = rword;
        case (size)
            SZ_BYTE: begin
                wword = {4{wdata[7:0]}};
                case (addr)
                    2'd0: begin byte_en = 4'b0001; rdata = {24'b0, rword[7:0]};   end
                    2'd1: begin byte_en = 4'b0010; rdata = {24'b0, rword[15:8]};  end
                    2'd2: begin byte_en = 4'b0100; rdata = {24'b0, rword[23:16]}; end
                    default: begin byte_en = 4'b1000; rdata = {24'b0, rword[31:24]}; end
                endcase
            end
            SZ_HALF: begin
                wword = {2{wdata[15:0]}};
                if (addr[1]) begin
                    byte_en = 4'b1100;
                    rdata   = {16'b0, rword[31:16]};
                end else begin
                    byte_en = 4'b0011;
                    rdata   = {16'b0, rword[15:0]};
                end
            end
            default: begin
                byte_en = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory slave with programmable wait latency and one-cycle ACKD_n.
// Define DMEM_ERR_EN to add the BERR_n out-of-range / misalignment indication.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        ACKD_n
`ifdef DMEM_ERR_EN
    ,
    output logic        BERR_n
`endif
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, 32'(DEPTH_WORDS)} << 2;

    state_e             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_q, wdata_q, rdata_q;
    logic [1:0]         size_q;
    logic               wr_q;

    logic [31:0]        cur_addr, cur_wdata, offset;
    logic [1:0]         cur_size;
    logic               cur_wr, in_range, enter_ack;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         byte_en;
    logic [31:0]        wword, rword, rdata;

    logic [31:0]        mem [DEPTH_WORDS];

    // With zero wait the commit edge is the accept edge, so the live bus is used in IDLE
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_size  = size_q;
        cur_wr    = wr_q;
        if (state == ST_IDLE) begin
            cur_addr  = DAD;
            cur_wdata = DDT;
            cur_size  = SIZE;
            cur_wr    = WRITE;
        end
        offset   = cur_addr - BASE_ADDR;
        in_range = (cur_addr >= BASE_ADDR) && ({1'b0, offset} < LIMIT);
        idx      = offset[IDX_W+1:2];
        rword    = mem[idx];
    end

    dmem_lane_align u_align (
        .size    (cur_size),
        .addr    (cur_addr[1:0]),
        .wdata   (cur_wdata),
        .rword   (rword),
        .byte_en (byte_en),
        .wword   (wword),
        .rdata   (rdata)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (MREQ) next_state = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt <= CNT_W'(1)) next_state = ST_ACK;
            end
            default: next_state = ST_IDLE;
        endcase
        enter_ack = (next_state == ST_ACK);
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && MREQ) begin
                addr_q <= DAD;
                size_q <= SIZE;
                wr_q   <= WRITE;
                cnt    <= CNT_W'(WAIT_CYCLES);
                if (WRITE) wdata_q <= DDT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (enter_ack) rdata_q <= (in_range && !cur_wr) ? rdata : 32'h0;
        end
    end

    // The array has no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (enter_ack && cur_wr && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign ACKD_n = (state != ST_ACK);
    assign DDT    = (state == ST_ACK && !wr_q) ? rdata_q : 32'bz;

`ifdef DMEM_ERR_EN
    logic misaligned, err_q;

    always_comb begin
        case (cur_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = cur_addr[0];
            default: misaligned = (cur_addr[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x)       err_q <= 1'b0;
        else if (enter_ack) err_q <= !in_range || misaligned;
    end

    assign BERR_n = !(state == ST_ACK && err_q);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES of 1, 0 and 3.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        mreq [3];
    logic        wr   [3];
    logic [1:0]  sz   [3];
    logic [31:0] dad  [3];
    logic [31:0] drv  [3];
    logic        oe   [3];
    wire  [31:0] obs_ddt [3];
    wire         ackd_n  [3];
    wire         berr_n  [3];

    int num_checks = 0;
    int num_fails  = 0;

    always #5 clk = ~clk;

    // Pull-ups make a released DDT read as all ones
    for (genvar k = 0; k < 3; k++) begin : g_dut
        wire [31:0] ddt_bus;
        for (genvar i = 0; i < 32; i++) begin : g_pu
            pullup pu (ddt_bus[i]);
        end
        assign ddt_bus    = oe[k] ? drv[k] : 32'bz;
        assign obs_ddt[k] = ddt_bus;

        dmem_responder #(
            .DEPTH_WORDS (16384),
            .BASE_ADDR   (32'h0001_0000),
            .WAIT_CYCLES ((k == 1) ? 0 : ((k == 2) ? 3 : 1))
        ) u_dut (
            .clk     (clk),
            .reset_x (reset_x),
            .MREQ    (mreq[k]),
            .WRITE   (wr[k]),
            .SIZE    (sz[k]),
            .DAD     (dad[k]),
            .DDT     (ddt_bus),
            .ACKD_n  (ackd_n[k])
`ifdef DMEM_ERR_EN
            ,
            .BERR_n  (berr_n[k])
`endif
        );
`ifndef DMEM_ERR_EN
        assign berr_n[k] = 1'b1;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One request held until its ack; reports ack latency in cycles from the request cycle
    task automatic applyStimulus(input int k, input logic w, input logic [1:0] s,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output int lat, output logic berr);
        rd   = 32'h0;
        lat  = -1;
        berr = 1'b1;
        @(posedge clk);
        #1;
        mreq[k] = 1'b1;
        wr[k]   = w;
        sz[k]   = s;
        dad[k]  = a;
        drv[k]  = d;
        oe[k]   = w;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (ackd_n[k] == 1'b0) begin
                lat  = n;
                rd   = obs_ddt[k];
                berr = berr_n[k];
                break;
            end
        end
        mreq[k] = 1'b0;
        oe[k]   = 1'b0;
        if (lat < 0) $display("[TB] FAIL ack timeout: got 0x%08h, expected 0x%08h", 32'hFFFF_FFFF, 32'h0);
    endtask

    logic [31:0] rd;
    int          lat;
    logic        berr;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got 0x%08h, expected 0x%08h", 32'h1, 32'h0);
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        reset_x = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mreq[k] = 1'b0; wr[k] = 1'b0; sz[k] = SZ_WORD;
            dad[k] = 32'h0; drv[k] = 32'h0; oe[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset ack0", 32'(ackd_n[0]), 32'h1);
        checkOutput("reset ack1", 32'(ackd_n[1]), 32'h1);
        checkOutput("reset ack2", 32'(ackd_n[2]), 32'h1);
        checkOutput("reset ddt",  obs_ddt[0], 32'hFFFF_FFFF);
        checkOutput("reset berr", 32'(berr_n[0]), 32'h1);
        reset_x = 1'b1;

        // Word store/load with one wait cycle
        applyStimulus(0, 1'b1, SZ_WORD, 32'h0001_0004, 32'hDEAD_BEEF, rd, lat, berr);
        checkOutput("st word lat", 32'(lat), 32'd2);
        applyStimulus(0, 1'b0, SZ_WORD, 32'h0001_0004, 32'h0, rd, lat, berr);
        checkOutput("ld word lat", 32'(lat), 32'd2);
        checkOutput("ld word", rd, 32'hDEAD_BEEF);
        checkOutput("ld word berr", 32'(berr), 32'h1);

        // Byte and half merges into one word
        applyStimulus(0, 1'b1, SZ_WORD, 32'h0001_0008, 32'h1122_3344, rd, lat, berr);
        applyStimulus(0, 1'b1, SZ_BYTE, 32'h0001_000A, 32'h0000_00AA, rd, lat, berr);
        applyStimulus(0, 1'b1, SZ_HALF, 32'h0001_0008, 32'h0000_5566, rd, lat, berr);
        applyStimulus(0, 1'b0, SZ_WORD, 32'h0001_0008, 32'h0, rd, lat, berr);
        checkOutput("merge word", rd, 32'h11AA_5566);
        applyStimulus(0, 1'b0, SZ_BYTE, 32'h0001_000B, 32'h0, rd, lat, berr);
        checkOutput("ld byte3", rd, 32'h0000_0011);
        applyStimulus(0, 1'b0, SZ_HALF, 32'h0001_000A, 32'h0, rd, lat, berr);
        checkOutput("ld half hi", rd, 32'h0000_11AA);
        applyStimulus(0, 1'b0, SZ_HALF, 32'h0001_0009, 32'h0, rd, lat, berr);
        checkOutput("ld half odd", rd, 32'h0000_5566);
`ifdef DMEM_ERR_EN
        checkOutput("berr misalign", 32'(berr), 32'h0);
`endif

        // Range boundaries
        applyStimulus(0, 1'b1, SZ_WORD, 32'h0001_0000, 32'hCAFE_F00D, rd, lat, berr);
        applyStimulus(0, 1'b1, SZ_WORD, 32'h0001_FFFC, 32'h7777_1234, rd, lat, berr);
        applyStimulus(0, 1'b0, SZ_WORD, 32'h0000_0000, 32'h0, rd, lat, berr);
        checkOutput("oor ld data", rd, 32'h0);
        checkOutput("oor ld lat", 32'(lat), 32'd2);
`ifdef DMEM_ERR_EN
        checkOutput("oor ld berr", 32'(berr), 32'h0);
`endif
        applyStimulus(0, 1'b1, SZ_WORD, 32'h0002_0000, 32'h1234_5678, rd, lat, berr);
        checkOutput("oor st lat", 32'(lat), 32'd2);
`ifdef DMEM_ERR_EN
        checkOutput("oor st berr", 32'(berr), 32'h0);
`endif
        applyStimulus(0, 1'b0, SZ_WORD, 32'h0001_0000, 32'h0, rd, lat, berr);
        checkOutput("word0 intact", rd, 32'hCAFE_F00D);
        applyStimulus(0, 1'b0, SZ_WORD, 32'h0001_FFFC, 32'h0, rd, lat, berr);
        checkOutput("last word", rd, 32'h7777_1234);

        // Zero wait, MREQ held across ACK: alternating IDLE/ACK cycles
        applyStimulus(1, 1'b1, SZ_WORD, 32'h0001_0020, 32'h0BAD_CAFE, rd, lat, berr);
        checkOutput("w0 st lat", 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        mreq[1] = 1'b1; wr[1] = 1'b0; sz[1] = SZ_WORD; dad[1] = 32'h0001_0020; oe[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("held ack %0d", i), 32'(ackd_n[1]), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("held ddt %0d", i), obs_ddt[1], (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0BAD_CAFE);
        end
        mreq[1] = 1'b0;
        @(negedge clk);
        checkOutput("held idle ddt", obs_ddt[1], 32'hFFFF_FFFF);

        // Reset during WAIT of a store loses the store
        applyStimulus(2, 1'b1, SZ_WORD, 32'h0001_0010, 32'hA5A5_A5A5, rd, lat, berr);
        checkOutput("w3 st lat", 32'(lat), 32'd4);
        @(posedge clk);
        #1;
        mreq[2] = 1'b1; wr[2] = 1'b1; sz[2] = SZ_WORD; dad[2] = 32'h0001_0010;
        drv[2] = 32'h5A5A_5A5A; oe[2] = 1'b1;
        repeat (2) @(negedge clk);
        reset_x = 1'b0;
        mreq[2] = 1'b0;
        oe[2]   = 1'b0;
        @(negedge clk);
        checkOutput("rst ack", 32'(ackd_n[2]), 32'h1);
        reset_x = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post rst ack %0d", i), 32'(ackd_n[2]), 32'h1);
        end
        applyStimulus(2, 1'b0, SZ_WORD, 32'h0001_0010, 32'h0, rd, lat, berr);
        checkOutput("rst ld lat", 32'(lat), 32'd4);
        checkOutput("rst ld data", rd, 32'hA5A5_A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
